// File: rtl/simframe_check.sv
// simframe_check: checks a framed AXI-Stream against a repeating expected pattern.
// The expected pattern arrives on its own stream before each frame. Every lane of
// every beat is compared against it, TLAST placement is checked against the row
// geometry, and error statistics are kept.
// Optional feature macro: SIMFRAME_CHECK_ERRCAPTURE_EN records the row and beat
// position of the first error. Without it, first_err_row and first_err_cycle are 0.
module simframe_check #(
    parameter int PATTERN_WIDTH = 32,
    parameter int INPUT_WIDTH   = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              CYCLES_PER_ROW,
    input  logic [15:0]              ROWS_PER_FRAME,
    input  logic [PATTERN_WIDTH-1:0] AXIS_EXP_TDATA,
    input  logic                     AXIS_EXP_TVALID,
    output logic                     AXIS_EXP_TREADY,
    input  logic [INPUT_WIDTH-1:0]   AXIS_IN_TDATA,
    input  logic                     AXIS_IN_TVALID,
    input  logic                     AXIS_IN_TLAST,
    output logic                     AXIS_IN_TREADY,
    input  logic                     clear_errors,
    output logic                     frame_done,
    output logic [31:0]              frame_count,
    output logic [31:0]              error_count,
    output logic                     data_error,
    output logic                     tlast_error,
    output logic [15:0]              first_err_row,
    output logic [15:0]              first_err_cycle
);

    localparam int LANES = INPUT_WIDTH / PATTERN_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state_q, state_d;
    logic [PATTERN_WIDTH-1:0] pattern_q, pattern_d;
    logic [15:0]              cyc_rem_q, cyc_rem_d;
    logic [15:0]              row_rem_q, row_rem_d;
    logic                     frame_done_q, frame_done_d;
    logic [31:0]              frame_count_q, frame_count_d;
    logic [31:0]              error_count_q, error_count_d;
    logic                     data_error_q, data_error_d;
    logic                     tlast_error_q, tlast_error_d;

    logic [LANES-1:0] lane_mismatch;
    logic             in_ready;
    logic             exp_ready;
    logic             in_hs;
    logic             exp_hs;
    logic             last_beat;
    logic             beat_data_err;
    logic             beat_tlast_err;
    logic             beat_err;
    logic [31:0]      err_base;

    // Per-lane comparison against the pattern held before any same-cycle reload
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_mismatch[gi] =
            (AXIS_IN_TDATA[gi*PATTERN_WIDTH +: PATTERN_WIDTH] != pattern_q);
    end

    assign last_beat      = (cyc_rem_q == 16'd0) && (row_rem_q == 16'd0);
    assign in_ready       = !reset && (state_q == RUN);
    assign in_hs          = AXIS_IN_TVALID && in_ready;
    // A new pattern is taken while idle, or while the final beat of a frame is accepted
    assign exp_ready      = !reset && ((state_q == IDLE) || (in_hs && last_beat));
    assign exp_hs         = AXIS_EXP_TVALID && exp_ready;
    assign beat_data_err  = in_hs && (|lane_mismatch);
    assign beat_tlast_err = in_hs && (AXIS_IN_TLAST != (cyc_rem_q == 16'd0));
    assign beat_err       = beat_data_err || beat_tlast_err;
    assign err_base       = clear_errors ? 32'd0 : error_count_q;

    // Next-state logic: frame sequencing, beat/row counting and error statistics
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        cyc_rem_d     = cyc_rem_q;
        row_rem_d     = row_rem_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        error_count_d = error_count_q;
        data_error_d  = data_error_q;
        tlast_error_d = tlast_error_q;

        case (state_q)
            IDLE: begin
                if (exp_hs) begin
                    pattern_d = AXIS_EXP_TDATA;
                    cyc_rem_d = CYCLES_PER_ROW - 16'd1;
                    row_rem_d = ROWS_PER_FRAME - 16'd1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (in_hs) begin
                    if (last_beat) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 32'd1;
                        cyc_rem_d     = CYCLES_PER_ROW - 16'd1;
                        row_rem_d     = ROWS_PER_FRAME - 16'd1;
                        if (exp_hs) begin
                            pattern_d = AXIS_EXP_TDATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (cyc_rem_q != 16'd0) begin
                        cyc_rem_d = cyc_rem_q - 16'd1;
                    end else begin
                        cyc_rem_d = CYCLES_PER_ROW - 16'd1;
                        row_rem_d = row_rem_q - 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear and an erroring beat in the same cycle: the clear is applied first,
        // then the error is counted on top of the cleared state.
        if (clear_errors) begin
            error_count_d = 32'd0;
            data_error_d  = 1'b0;
            tlast_error_d = 1'b0;
        end
        if (beat_err) begin
            error_count_d = (err_base == 32'hFFFF_FFFF) ? err_base : err_base + 32'd1;
            data_error_d  = (clear_errors ? 1'b0 : data_error_q) | beat_data_err;
            tlast_error_d = (clear_errors ? 1'b0 : tlast_error_q) | beat_tlast_err;
        end
    end

    // State and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pattern_q     <= '0;
            cyc_rem_q     <= 16'd0;
            row_rem_q     <= 16'd0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 32'd0;
            error_count_q <= 32'd0;
            data_error_q  <= 1'b0;
            tlast_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            cyc_rem_q     <= cyc_rem_d;
            row_rem_q     <= row_rem_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
            data_error_q  <= data_error_d;
            tlast_error_q <= tlast_error_d;
        end
    end

`ifdef SIMFRAME_CHECK_ERRCAPTURE_EN
    logic        err_seen_q, err_seen_d;
    logic [15:0] first_err_row_q, first_err_row_d;
    logic [15:0] first_err_cycle_q, first_err_cycle_d;

    // Capture the position of the first erroring beat since reset or the last clear
    always_comb begin
        err_seen_d        = err_seen_q;
        first_err_row_d   = first_err_row_q;
        first_err_cycle_d = first_err_cycle_q;
        if (clear_errors) begin
            err_seen_d        = 1'b0;
            first_err_row_d   = 16'd0;
            first_err_cycle_d = 16'd0;
        end
        if (beat_err && (clear_errors || !err_seen_q)) begin
            err_seen_d        = 1'b1;
            first_err_row_d   = ROWS_PER_FRAME - 16'd1 - row_rem_q;
            first_err_cycle_d = CYCLES_PER_ROW - 16'd1 - cyc_rem_q;
        end
    end

    // First-error capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            err_seen_q        <= 1'b0;
            first_err_row_q   <= 16'd0;
            first_err_cycle_q <= 16'd0;
        end else begin
            err_seen_q        <= err_seen_d;
            first_err_row_q   <= first_err_row_d;
            first_err_cycle_q <= first_err_cycle_d;
        end
    end

    assign first_err_row   = first_err_row_q;
    assign first_err_cycle = first_err_cycle_q;
`else
    assign first_err_row   = 16'd0;
    assign first_err_cycle = 16'd0;
`endif

    assign AXIS_EXP_TREADY = exp_ready;
    assign AXIS_IN_TREADY  = in_ready;
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_count_q;
    assign error_count     = error_count_q;
    assign data_error      = data_error_q;
    assign tlast_error     = tlast_error_q;

endmodule
